// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - MIPS ID stage: register file, control decode, branch resolve, ID/EX register
module instruction_decode #(
    parameter int B = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  instruction,
    input  logic [B-1:0] pc_incrementado,
    input  logic         stall,
    input  logic         flush,
    input  logic         wb_reg_write,
    input  logic [4:0]   wb_write_reg,
    input  logic [31:0]  wb_write_data,
    output logic [B-1:0] pc_branch,
    output logic         PCSrc,
    output logic [B-1:0] ex_pc_incrementado,
    output logic [31:0]  ex_read_data1,
    output logic [31:0]  ex_read_data2,
    output logic [31:0]  ex_sign_ext,
    output logic [4:0]   ex_rs,
    output logic [4:0]   ex_rt,
    output logic [4:0]   ex_rd,
    output logic         ex_reg_dst,
    output logic         ex_alu_src,
    output logic         ex_mem_read,
    output logic         ex_mem_write,
    output logic         ex_mem_to_reg,
    output logic         ex_reg_write,
    output logic [1:0]   ex_alu_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [25:0] w_target;
    logic [31:0] w_sign_ext;
    logic [31:0] w_rd1, w_rd2;
    logic        w_taken;
    logic signed [33:0] w_off;

    logic w_reg_dst, w_alu_src, w_mem_read, w_mem_write, w_mem_to_reg, w_reg_write;
    logic [1:0] w_alu_op;

    logic [31:0] r_regs [0:31];

    assign w_opcode   = instruction[31:26];
    assign w_rs       = instruction[25:21];
    assign w_rt       = instruction[20:16];
    assign w_rd       = instruction[15:11];
    assign w_target   = instruction[25:0];
    assign w_sign_ext = {{16{instruction[15]}}, instruction[15:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (wb_reg_write && wb_write_reg != 5'd0) begin
            r_regs[wb_write_reg] <= wb_write_data;
        end
    end

    // Same-cycle writeback is forwarded so the branch compare and ID/EX see fresh data
    always_comb begin
        w_rd1 = r_regs[w_rs];
        w_rd2 = r_regs[w_rt];
        if (wb_reg_write && wb_write_reg == w_rs) w_rd1 = wb_write_data;
        if (wb_reg_write && wb_write_reg == w_rt) w_rd2 = wb_write_data;
        if (w_rs == 5'd0) w_rd1 = 32'd0;
        if (w_rt == 5'd0) w_rd2 = 32'd0;
    end

    always_comb begin
        w_reg_dst    = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_op     = 2'b00;
        case (w_opcode)
            OP_RTYPE: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
                w_alu_op    = 2'b10;
            end
            OP_LW: begin
                w_alu_src    = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            OP_SW: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            OP_ADDI: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
            end
            OP_BEQ, OP_BNE: w_alu_op = 2'b01;
            default: ;
        endcase
    end

    assign w_taken = ((w_opcode == OP_BEQ) && (w_rd1 == w_rd2)) ||
                     ((w_opcode == OP_BNE) && (w_rd1 != w_rd2)) ||
                     (w_opcode == OP_J);
    assign PCSrc   = w_taken & ~stall & ~flush & ~reset;

    // Signed sizing cast sign-extends the word offset to the PC width
    assign w_off     = {w_sign_ext, 2'b00};
    assign pc_branch = (w_opcode == OP_J) ? {pc_incrementado[B-1:28], w_target, 2'b00}
                                          : pc_incrementado + B'(w_off);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_pc_incrementado <= '0;
            ex_read_data1      <= 32'd0;
            ex_read_data2      <= 32'd0;
            ex_sign_ext        <= 32'd0;
            ex_rs              <= 5'd0;
            ex_rt              <= 5'd0;
            ex_rd              <= 5'd0;
            ex_reg_dst         <= 1'b0;
            ex_alu_src         <= 1'b0;
            ex_mem_read        <= 1'b0;
            ex_mem_write       <= 1'b0;
            ex_mem_to_reg      <= 1'b0;
            ex_reg_write       <= 1'b0;
            ex_alu_op          <= 2'b00;
        end else begin
            ex_pc_incrementado <= pc_incrementado;
            ex_read_data1      <= w_rd1;
            ex_read_data2      <= w_rd2;
            ex_sign_ext        <= w_sign_ext;
            ex_rs              <= w_rs;
            ex_rt              <= w_rt;
            ex_rd              <= w_rd;
            if (stall || flush) begin
                ex_reg_dst    <= 1'b0;
                ex_alu_src    <= 1'b0;
                ex_mem_read   <= 1'b0;
                ex_mem_write  <= 1'b0;
                ex_mem_to_reg <= 1'b0;
                ex_reg_write  <= 1'b0;
                ex_alu_op     <= 2'b00;
            end else begin
                ex_reg_dst    <= w_reg_dst;
                ex_alu_src    <= w_alu_src;
                ex_mem_read   <= w_mem_read;
                ex_mem_write  <= w_mem_write;
                ex_mem_to_reg <= w_mem_to_reg;
                ex_reg_write  <= w_reg_write;
                ex_alu_op     <= w_alu_op;
            end
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - randomized model-checked bench for instruction_decode
module tb_instruction_decode;

    localparam int B = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sx;
        logic [4:0]  rs, rt, rd;
        logic reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write;
        logic [1:0] alu_op;
    } ex_t;

    logic         clk, reset;
    logic [31:0]  instruction;
    logic [B-1:0] pc_incrementado;
    logic         stall, flush, wb_reg_write;
    logic [4:0]   wb_write_reg;
    logic [31:0]  wb_write_data;
    logic [B-1:0] pc_branch;
    logic         PCSrc;
    logic [B-1:0] ex_pc_incrementado;
    logic [31:0]  ex_read_data1, ex_read_data2, ex_sign_ext;
    logic [4:0]   ex_rs, ex_rt, ex_rd;
    logic ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
    logic [1:0]   ex_alu_op;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] m_regs [32];
    ex_t         m_ex = '0;

    instruction_decode #(.B(B)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .pc_incrementado(pc_incrementado),
        .stall(stall), .flush(flush), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .pc_branch(pc_branch), .PCSrc(PCSrc),
        .ex_pc_incrementado(ex_pc_incrementado), .ex_read_data1(ex_read_data1),
        .ex_read_data2(ex_read_data2), .ex_sign_ext(ex_sign_ext), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_alu_op(ex_alu_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_read(logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_reg_write && wb_write_reg == idx) return wb_write_data;
        return m_regs[idx];
    endfunction

    function automatic ex_t model_ex();
        ex_t e;
        logic [5:0] op;
        op = instruction[31:26];
        e = '0;
        e.pc  = pc_incrementado;
        e.rs  = instruction[25:21];
        e.rt  = instruction[20:16];
        e.rd  = instruction[15:11];
        e.rd1 = model_read(e.rs);
        e.rd2 = model_read(e.rt);
        e.sx  = 32'($signed(instruction[15:0]));
        if (!stall && !flush) begin
            if (op == 6'd0)       begin e.reg_dst = 1; e.reg_write = 1; e.alu_op = 2; end
            else if (op == 6'd35) begin e.alu_src = 1; e.mem_read = 1; e.mem_to_reg = 1; e.reg_write = 1; end
            else if (op == 6'd43) begin e.alu_src = 1; e.mem_write = 1; end
            else if (op == 6'd8)  begin e.alu_src = 1; e.reg_write = 1; end
            else if (op == 6'd4 || op == 6'd5) e.alu_op = 1;
        end
        return e;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_ex = '0;
        end else begin
            m_ex = model_ex();
            if (wb_reg_write && wb_write_reg != 5'd0) m_regs[wb_write_reg] = wb_write_data;
        end
    end

    ex_t         cmp_exp, cmp_act;
    logic        cmp_src;
    logic [31:0] cmp_br, cmp_a, cmp_b;
    logic [5:0]  cmp_op;

    always @(negedge clk) begin
        cmp_exp = reset ? '0 : m_ex;
        cmp_act = {ex_pc_incrementado, ex_read_data1, ex_read_data2, ex_sign_ext, ex_rs, ex_rt, ex_rd,
                   ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_alu_op};
        n_cmp++;
        if (cmp_act !== cmp_exp) begin
            n_fail++;
            $display("FAIL ex_regs @%0t: got %h expected %h", $time, cmp_act, cmp_exp);
        end
        cmp_op = instruction[31:26];
        cmp_a  = model_read(instruction[25:21]);
        cmp_b  = model_read(instruction[20:16]);
        cmp_src = !reset && !stall && !flush &&
                  ((cmp_op == 6'd4 && cmp_a == cmp_b) || (cmp_op == 6'd5 && cmp_a != cmp_b) || cmp_op == 6'd2);
        n_cmp++;
        if (PCSrc !== cmp_src) begin
            n_fail++;
            $display("FAIL pcsrc @%0t: got %b expected %b", $time, PCSrc, cmp_src);
        end
        if (cmp_src) begin
            if (cmp_op == 6'd2) cmp_br = {pc_incrementado[31:28], instruction[25:0], 2'b00};
            else                cmp_br = pc_incrementado + 32'($signed(instruction[15:0])) * 4;
            n_cmp++;
            if (pc_branch !== cmp_br) begin
                n_fail++;
                $display("FAIL pc_branch @%0t: got %h expected %h", $time, pc_branch, cmp_br);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic st, input logic fl,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd);
        instruction = ins; pc_incrementado = pc; stall = st; flush = fl;
        wb_reg_write = we; wb_write_reg = wr; wb_write_data = wd;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'($urandom_range(1, 3));
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    logic [5:0] ops [8] = '{6'd0, 6'd35, 6'd43, 6'd8, 6'd4, 6'd5, 6'd2, 6'd63};

    initial begin
        logic [5:0]  op;
        logic [31:0] ins;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        reset = 1'b1;
        drive(32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        step();
        step();
        reset = 1'b0;

        after_edge();
        chk("rtype_reg_dst", {31'd0, ex_reg_dst}, 32'd1);
        chk("rtype_reg_write", {31'd0, ex_reg_write}, 32'd1);
        chk("rtype_alu_op", {30'd0, ex_alu_op}, 32'd2);
        chk("rtype_pcsrc", {31'd0, PCSrc}, 32'd0);

        step(); drive(32'h0, 32'h0, 0, 0, 1, 5'd8, 32'h5);
        step(); drive(32'h8D09FFFC, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        after_edge();
        chk("lw_rd1", ex_read_data1, 32'h5);
        chk("lw_sign_ext", ex_sign_ext, 32'hFFFFFFFC);
        chk("lw_ctrl", {28'd0, ex_mem_read, ex_mem_to_reg, ex_alu_src, ex_reg_write}, 32'hF);

        step(); drive(32'h00600820, 32'h0, 0, 0, 1, 5'd3, 32'hDEADBEEF);
        after_edge();
        chk("bypass_rd1", ex_read_data1, 32'hDEADBEEF);
        step(); drive(32'h00000020, 32'h0, 0, 0, 1, 5'd0, 32'h1234);
        after_edge();
        chk("r0_bypass", ex_read_data1, 32'h0);
        step(); drive(32'h00000020, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        after_edge();
        chk("r0_stored", ex_read_data2, 32'h0);

        step(); drive(32'h10000003, 32'h104, 0, 0, 0, 5'd0, 32'h0);
        #1 chk("beq_pcsrc", {31'd0, PCSrc}, 32'd1);
        chk("beq_target", pc_branch, 32'h110);
        step(); drive(32'h14000003, 32'h104, 0, 0, 0, 5'd0, 32'h0);
        #1 chk("bne_pcsrc", {31'd0, PCSrc}, 32'd0);
        step(); drive(32'h1000FFFF, 32'h4, 0, 0, 0, 5'd0, 32'h0);
        #1 chk("beq_neg_target", pc_branch, 32'h0);

        step(); drive(32'h08000040, 32'h40000008, 0, 0, 0, 5'd0, 32'h0);
        #1 chk("j_target", pc_branch, 32'h40000100);
        chk("j_pcsrc", {31'd0, PCSrc}, 32'd1);
        step(); drive(32'h08000040, 32'h40000008, 1, 0, 0, 5'd0, 32'h0);
        #1 chk("j_stall_pcsrc", {31'd0, PCSrc}, 32'd0);
        step(); drive(32'h00000000, 32'h0, 1, 0, 0, 5'd0, 32'h0);
        after_edge();
        chk("stall_ctrl", {25'd0, ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_alu_op}, 32'h0);

        step(); drive(32'hAD090000, 32'h0, 0, 1, 0, 5'd0, 32'h0);
        after_edge();
        chk("sw_flush_mem_write", {31'd0, ex_mem_write}, 32'd0);
        step(); drive(32'hAD090000, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        after_edge();
        chk("sw_mem_write", {31'd0, ex_mem_write}, 32'd1);

        step(); drive(32'h00000000, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        after_edge();
        chk("pre_reset_reg_write", {31'd0, ex_reg_write}, 32'd1);
        #1 reset = 1'b1;
        #1 chk("async_reset_reg_write", {31'd0, ex_reg_write}, 32'd0);
        step(); reset = 1'b0;
        drive(32'h01034820, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        after_edge();
        chk("reset_r8", ex_read_data1, 32'h0);
        chk("reset_r3", ex_read_data2, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            step();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 199) == 0) reset = 1'b1;
            op  = ops[$urandom_range(0, 7)];
            if (op == 6'd63) op = 6'($urandom);
            ins = {op, pick_reg(), pick_reg(), 16'($urandom)};
            drive(ins, $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 2) != 0), pick_reg(), $urandom);
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Second pipeline stage of the MIPS core; consumes the IF/ID-aligned instruction and pc_incrementado from instruction fetch.
- Contains the 32x32 register file, sign extension, control decode and the ID/EX pipeline register.
- Resolves beq/bne/j in ID and drives pc_branch/PCSrc back to fetch, closing the fetch redirect interface from the receiving end.

Parameters:
B, 32, PC width (pc_incrementado, pc_branch, ex_pc_incrementado)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
instruction  input  32  instruction held in IF/ID
pc_incrementado  input  B  PC+4 of that instruction
stall  input  1  insert bubble into ID/EX; suppress redirect
flush  input  1  insert bubble into ID/EX; suppress redirect
wb_reg_write  input  1  writeback enable
wb_write_reg  input  5  writeback destination register
wb_write_data  input  32  writeback data
pc_branch  output  B  redirect target to fetch (combinational)
PCSrc  output  1  take pc_branch on next clk (combinational)
ex_pc_incrementado  output  B  registered PC+4
ex_read_data1, ex_read_data2  output  32 each  registered rs/rt values
ex_sign_ext  output  32  registered sign-extended imm[15:0]
ex_rs, ex_rt, ex_rd  output  5 each  registered register fields
ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  output  1 each  registered controls
ex_alu_op  output  2  registered ALU op class

Behaviour:
- Reset (async): all 32 registers = 0; all ex_* outputs = 0. PCSrc = 0 while reset is asserted.
- Fields:
  - opcode = instruction[31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0], target = [25:0].
  - sign_ext = {{16{imm[15]}}, imm}.
- Register file:
  - Written on posedge clk when wb_reg_write=1 and wb_write_reg != 0.
  - Register 0 always reads 0, and writes to it are ignored.
  - Read is combinational with same-cycle bypass: if wb_reg_write=1, wb_write_reg == rs (or rt), and that index != 0, the read returns wb_write_data.
- Control decode:
  - R-type 000000: reg_dst=1, reg_write=1, alu_op=10.
  - lw 100011: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, alu_op=00.
  - sw 101011: alu_src=1, mem_write=1, alu_op=00.
  - addi 001000: alu_src=1, reg_write=1, alu_op=00.
  - beq 000100, bne 000101: alu_op=01, all other controls 0.
  - j 000010: all controls 0.
  - Any other opcode: all controls 0 (bubble).
- Branch resolution (combinational, uses bypassed read values):
  - taken = (beq & rd1==rd2) | (bne & rd1!=rd2) | j.
  - PCSrc = taken & ~stall & ~flush & ~reset.
  - pc_branch for j = {pc_incrementado[B-1:28], target, 2'b00}.
  - pc_branch otherwise = pc_incrementado + (sign_ext << 2), modulo 2^B, wrap-around allowed.
  - pc_branch is don't-care when PCSrc=0 but must be deterministic.
- ID/EX register (posedge clk, latency 1):
  - Normal cycle: all ex_* outputs load the current decode.
  - stall=1 or flush=1: the six control bits and ex_alu_op load 0; data fields load normally.
  - stall and flush together behave as flush.
- Writeback write and ID/EX capture in the same edge are independent. The bypass guarantees that the captured ex_read_data reflects the write.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. The first edge after release captures normally.

Test Plan:
- Reset, then release with instruction=0x00000000 -> after 1 clk all ex_* = 0 except ex_reg_dst=1, ex_reg_write=1, ex_alu_op=10; PCSrc=0.
- Write r8=0x00000005 via wb (1 clk). Then lw r9,-4(r8) (0x8D09FFFC) -> ex_read_data1=5, ex_sign_ext=0xFFFFFFFC, mem_read=mem_to_reg=alu_src=reg_write=1.
- Bypass: wb write r3=0xDEADBEEF in the same cycle as add r1,r3,r0 (0x00600820) -> ex_read_data1=0xDEADBEEF. Separately, a wb write to r0=0x1234 -> r0 still reads 0.
- beq r0,r0,+3 (0x10000003) with pc_incrementado=0x00000104 -> PCSrc=1, pc_branch=0x00000110. bne r0,r0 -> PCSrc=0. Negative offset 0xFFFF with pc_incrementado=0x00000004 -> pc_branch=0x00000000.
- j 0x0000040 (0x08000040) with pc_incrementado=0x40000008 -> pc_branch=0x40000100, PCSrc=1. Repeat with stall=1 -> PCSrc=0, ex controls 0 after clk.
- sw during flush=1 -> ex_mem_write=0. Assert reset between clk edges with ex_reg_write=1 -> ex_reg_write drops to 0 immediately and all registers read 0.
